// File: rtl/px_adc_responder.sv
// px_adc_responder: FPGA-side emulation of the 3-wire pixel-ADC serial link; optional PX_ADC_RAMP_PATTERN_EN
// replaces the sample handshake with an internal ramp word source.
module px_adc_responder #(
    parameter int DATA_BITS  = 10,
    parameter int LEAD_ZEROS = 3,
    parameter int FRAME_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adc_cs,
    input  logic                 adc_sclk,
    output logic                 adc_sdata,
    output logic                 adc_sdata_oe,
    input  logic [DATA_BITS-1:0] sample_data,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 frame_done,
    output logic                 frame_short,
    output logic                 underrun
);
    localparam int CW    = $clog2(FRAME_BITS);
    localparam int TRAIL = FRAME_BITS - LEAD_ZEROS - DATA_BITS;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t                state;
    logic [2:0]            cs_sync, sclk_sync;
    logic                  cs_fall, cs_rise, sclk_fall, start, fresh;
    logic [FRAME_BITS-1:0] shreg, shifted, frame_word;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_BITS-1:0]  word;

    always_ff @(posedge clk)
        if (rst) begin
            cs_sync   <= '1;
            sclk_sync <= '1;
        end else begin
            cs_sync   <= {cs_sync[1:0], adc_cs};
            sclk_sync <= {sclk_sync[1:0], adc_sclk};
        end

    assign cs_fall    = cs_sync[2] & ~cs_sync[1];
    assign cs_rise    = ~cs_sync[2] & cs_sync[1];
    assign sclk_fall  = sclk_sync[2] & ~sclk_sync[1];
    assign start      = state == IDLE && cs_fall;
    assign shifted    = shreg << 1;
    assign frame_word = FRAME_BITS'(word) << TRAIL;

`ifdef PX_ADC_RAMP_PATTERN_EN
    logic [DATA_BITS-1:0] ramp;
    logic                 unused_ok;

    always_ff @(posedge clk)
        if (rst)
            ramp <= '0;
        else if (start)
            ramp <= ramp + 1'b1;

    assign word         = ramp;
    assign fresh        = 1'b1;
    assign sample_ready = 1'b0;
    assign unused_ok    = ^{sample_data, sample_valid};
`else
    logic [DATA_BITS-1:0] hold_word, last_word;
    logic                 pending;

    // A frame start consumes the pending sample; otherwise the accept path may load a new one in the same cycle.
    always_ff @(posedge clk)
        if (rst) begin
            pending   <= 1'b0;
            hold_word <= '0;
            last_word <= '0;
        end else begin
            if (start)
                last_word <= word;
            if (start && pending)
                pending <= 1'b0;
            else if (sample_valid && !pending) begin
                pending   <= 1'b1;
                hold_word <= sample_data;
            end
        end

    assign word         = pending ? hold_word : last_word;
    assign fresh        = pending;
    assign sample_ready = !pending;
`endif

    always_ff @(posedge clk)
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            adc_sdata    <= 1'b0;
            adc_sdata_oe <= 1'b0;
            frame_done   <= 1'b0;
            frame_short  <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_done  <= cs_rise && state == HOLD;
            frame_short <= cs_rise && state == SHIFT;
            underrun    <= start && !fresh;
            if (cs_rise) begin
                state        <= IDLE;
                adc_sdata    <= 1'b0;
                adc_sdata_oe <= 1'b0;
            end else if (start) begin
                state        <= SHIFT;
                shreg        <= frame_word;
                adc_sdata    <= frame_word[FRAME_BITS-1];
                adc_sdata_oe <= 1'b1;
                bit_cnt      <= '0;
            end else if (sclk_fall && state == SHIFT) begin
                shreg     <= shifted;
                adc_sdata <= shifted[FRAME_BITS-1];
                bit_cnt   <= bit_cnt + 1'b1;
                if (bit_cnt == CW'(FRAME_BITS - 1))
                    state <= HOLD;
            end else if (sclk_fall && state == HOLD)
                adc_sdata <= 1'b0;
        end
endmodule

// File: tb/tb_px_adc_responder.sv
// tb_px_adc_responder: drives the capture-master side of the ADC link and checks received bits and pulses
// against a word-level model of the responder.
module tb_px_adc_responder;
    localparam int D = 10, L = 3, F = 16;
`ifdef PX_ADC_RAMP_PATTERN_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic         clk = 1'b0, rst = 1'b1, adc_cs = 1'b1, adc_sclk = 1'b1, sample_valid = 1'b0;
    logic [D-1:0] sample_data = '0;
    logic         adc_sdata, adc_sdata_oe, sample_ready, frame_done, frame_short, underrun;

    int errors = 0, checks = 0;
    int n_done = 0, n_short = 0, n_under = 0, n_ready = 0;

    logic         pend = 1'b0;
    logic [D-1:0] pval = '0, last = '0, ramp_m = '0;

    px_adc_responder #(.DATA_BITS(D), .LEAD_ZEROS(L), .FRAME_BITS(F)) dut (
        .clk(clk), .rst(rst), .adc_cs(adc_cs), .adc_sclk(adc_sclk),
        .adc_sdata(adc_sdata), .adc_sdata_oe(adc_sdata_oe),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .frame_done(frame_done), .frame_short(frame_short), .underrun(underrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_done  += int'(frame_done);
        n_short += int'(frame_short);
        n_under += int'(underrun);
        n_ready += int'(sample_ready);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [D-1:0] v);
        chk("push_ready", 32'(sample_ready), 32'd1);
        sample_data  = v;
        sample_valid = 1'b1;
        cyc(1);
        sample_valid = 1'b0;
        sample_data  = '0;
        pend = 1'b1;
        pval = v;
    endtask

    task automatic sclk_pulse();
        adc_sclk = 1'b0;
        cyc(5);
        adc_sclk = 1'b1;
        cyc(5);
    endtask

    // Runs one frame of n SCLK falls; the master samples data just before each fall.
    task automatic run_frame(input int n, input string tag);
        logic [19:0]  got, exp;
        logic [D-1:0] w;
        logic [F-1:0] fw;
        logic         und;
        int           d0, s0, u0;
        got = '0;
        exp = '0;
        if (RAMP) begin
            w = ramp_m;
            ramp_m = ramp_m + 1'b1;
            und = 1'b0;
        end else if (pend) begin
            w = pval;
            pend = 1'b0;
            und = 1'b0;
        end else begin
            w = last;
            und = 1'b1;
        end
        last = w;
        fw = F'(w) << (F - L - D);
        for (int k = 0; k < n; k++)
            if (k < F) exp[k] = fw[F-1-k];
        d0 = n_done;
        s0 = n_short;
        u0 = n_under;
        adc_cs = 1'b0;
        cyc(6);
        chk({tag, "_oe_on"}, 32'(adc_sdata_oe), 32'd1);
        for (int k = 0; k < n; k++) begin
            got[k] = adc_sdata;
            sclk_pulse();
        end
        adc_cs = 1'b1;
        cyc(6);
        chk({tag, "_oe_off"}, 32'(adc_sdata_oe), 32'd0);
        chk({tag, "_sdata_idle"}, 32'(adc_sdata), 32'd0);
        chk({tag, "_bits"}, 32'(got), 32'(exp));
        chk({tag, "_done"}, 32'(n_done - d0), 32'(n >= F));
        chk({tag, "_short"}, 32'(n_short - s0), 32'(n < F));
        chk({tag, "_underrun"}, 32'(n_under - u0), 32'(und));
    endtask

    initial begin
        int d0, s0, u0, nf;
        cyc(3);
        chk("rst_sdata", 32'(adc_sdata), 32'd0);
        chk("rst_oe", 32'(adc_sdata_oe), 32'd0);
        chk("rst_ready", 32'(sample_ready), 32'(!RAMP));
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_short", 32'(frame_short), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        rst = 1'b0;
        cyc(3);
        if (RAMP) begin
            u0 = n_under;
            n_ready = 0;
            for (int i = 0; i < 1025; i++) begin
                if (i < 3 || i >= 1022)
                    run_frame(16, $sformatf("ramp%0d", i));
                else begin
                    ramp_m = ramp_m + 1'b1;
                    adc_cs = 1'b0;
                    cyc(6);
                    adc_cs = 1'b1;
                    cyc(6);
                end
            end
            chk("ramp_ready_never", 32'(n_ready), 32'd0);
            chk("ramp_no_underrun", 32'(n_under - u0), 32'd0);
        end else begin
            push(10'h2A5);
            run_frame(16, "basic");
            push(10'h155);
            run_frame(16, "b2b_a");
            run_frame(16, "b2b_b");
            push(10'h3FF);
            run_frame(7, "short");
            push(10'h001);
            run_frame(16, "after_short");
            push(10'h3FF);
            run_frame(20, "long");
            push(10'h1C3);
            adc_cs = 1'b0;
            cyc(6);
            repeat (5) sclk_pulse();
            d0 = n_done;
            s0 = n_short;
            u0 = n_under;
            rst = 1'b1;
            cyc(1);
            chk("midrst_oe", 32'(adc_sdata_oe), 32'd0);
            chk("midrst_ready", 32'(sample_ready), 32'd1);
            chk("midrst_sdata", 32'(adc_sdata), 32'd0);
            adc_cs = 1'b1;
            cyc(6);
            rst = 1'b0;
            cyc(3);
            chk("midrst_pulses", 32'((n_done - d0) + (n_short - s0) + (n_under - u0)), 32'd0);
            pend = 1'b0;
            last = '0;
            run_frame(16, "post_rst");
            for (int i = 0; i < 8; i++) begin
                if (!pend && $urandom_range(0, 2) != 0)
                    push(D'($urandom));
                nf = $urandom_range(0, 20);
                run_frame(nf, $sformatf("rnd%0d", i));
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
